// File: rtl/booth_pkg.sv
// Shared Booth radix-4 types and the 3-bit window encoder used by the
// sequencer and the partial-product reference model.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic sign;
        logic one;
        logic two;
    } booth_digit_t;

    localparam booth_digit_t BOOTH_ZERO = '{sign: 1'b0, one: 1'b0, two: 1'b0};

    // Window is (y[2i+1], y[2i], y[2i-1]); 3'b111 is zero and keeps sign clear.
    function automatic booth_digit_t booth_encode(input logic [2:0] b);
        booth_digit_t d;
        d.one  = b[1] ^ b[0];
        d.two  = (b[2] & ~b[1] & ~b[0]) | (~b[2] & b[1] & b[0]);
        d.sign = b[2] & ~(b[1] & b[0]);
        return d;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational radix-4 Booth encoder: 3-bit multiplier window to sign/one/two.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] i_bits,
    output logic       o_sign,
    output logic       o_one,
    output logic       o_two
);

    booth_digit_t w_dig;

    assign w_dig  = booth_encode(i_bits);
    assign o_sign = w_dig.sign;
    assign o_one  = w_dig.one;
    assign o_two  = w_dig.two;

endmodule

// File: rtl/booth_digit_sequencer.sv
// Recodes one multiplier operand into radix-4 Booth digits, LSD first,
// one digit per output handshake.
module booth_digit_sequencer
    import booth_pkg::*;
#(
    parameter  int WIDTH  = 32,
    localparam int NDIG_U = WIDTH / 2 + 1,
    localparam int IDXW   = $clog2(WIDTH / 2 + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_tc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic             out_one,
    output logic             out_two,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH+2:0]    r_sreg;
    logic [IDXW-1:0]     r_idx;
    logic [IDXW-1:0]     r_last_idx;

    logic                w_accept;
    logic                w_shift;
    logic                w_ext;
    logic                w_emit;
    logic                w_last;
    logic                w_sign;
    logic                w_one;
    logic                w_two;

    assign w_emit = (r_state == EMIT);
    assign w_last = (r_idx == r_last_idx);
    assign w_ext  = in_tc & in_y[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // flush outranks both handshakes; in IDLE it also masks in_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Register holds {ext, ext, y, y[-1]=0}; digit i always sits in bits [2:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg     <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
        end else if (w_accept) begin
            r_sreg     <= {w_ext, w_ext, in_y, 1'b0};
            r_idx      <= '0;
            r_last_idx <= in_tc ? IDXW'(WIDTH / 2 - 1) : IDXW'(NDIG_U - 1);
        end else if (w_shift) begin
            r_sreg     <= r_sreg >> 2;
            r_idx      <= r_idx + IDXW'(1);
        end
    end

    booth_digit_enc u_enc (
        .i_bits (r_sreg[2:0]),
        .o_sign (w_sign),
        .o_one  (w_one),
        .o_two  (w_two)
    );

    assign in_ready  = ~w_emit;
    assign out_valid = w_emit;
    assign out_sign  = w_emit & w_sign;
    assign out_one   = w_emit & w_one;
    assign out_two   = w_emit & w_two;
    assign out_idx   = w_emit ? r_idx : '0;
    assign out_last  = w_emit & w_last;

endmodule
